ras_spec: RTL and testbench
===========================

RAS_SPEC -- requirements
Module: ras_spec

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning core configuration; VLEN sets the address width.
REQ-002 SHALL have parameter ras_t, default logic, meaning entry struct with fields ra [VLEN] and valid.
REQ-003 SHALL have parameter DEPTH, default 8, meaning stack entries; power of two, at least 2.
REQ-004 SHALL have parameter NUM_CKPT, default 4, meaning checkpoint slots; at least 1.
REQ-005 SHALL have parameter CNT_W, default 2, meaning recursion counter width (REQ-025).
REQ-006 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-007 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have port flush_bp_i, input, 1, meaning branch-prediction flush.
REQ-009 SHALL have ports push_i and pop_i, input, 1 each, meaning call push and return pop.
REQ-010 SHALL have port data_i, input, VLEN, meaning the return address to push.
REQ-011 SHALL have ports ckpt_save_i, input, 1, and ckpt_save_id_i, input, $clog2(NUM_CKPT), meaning snapshot request and target slot.
REQ-012 SHALL have ports ckpt_restore_i, input, 1, and ckpt_restore_id_i, input, $clog2(NUM_CKPT), meaning misprediction recovery and source slot.
REQ-013 SHALL have port data_o, output, ras_t, meaning the predicted return (top of stack).
REQ-014 SHALL have ports empty_o and overflow_o, output, 1 each, meaning stack empty and oldest entry lost this cycle.

Function
REQ-015 SHALL implement a circular buffer: tos_q pointer ($clog2(DEPTH) bits, wraps modulo DEPTH) and count_q (0..DEPTH).
REQ-016 SHALL drive data_o combinationally as stack_q[tos_q] when count_q>0, else all-zero with valid=0; empty_o = (count_q==0).
REQ-017 Push only: tos+1 (wrap), write {data_i, valid=1}, count saturates at DEPTH; when count_q==DEPTH, overflow_o=1 in the same cycle and the oldest entry is overwritten.
REQ-018 Pop only with count_q>0: tos-1 (wrap), count-1; entry contents are retained so restore can recover them; pop when empty is a no-op.
REQ-019 Push and pop in the same cycle: overwrite stack_q[tos_q] with {data_i,1}; tos unchanged; count = max(count_q,1).
REQ-020 Save SHALL store the pre-update {tos_q, count_q, stack_q[tos_q]} into the slot and mark it valid; the registered result is visible from the next cycle.
REQ-021 Restore from a valid slot SHALL load tos and count and rewrite stack[saved tos] with the saved entry; push and pop in that cycle are ignored; restore from an invalid slot is a no-op.
REQ-022 Save and restore in the same cycle SHALL both act; if the slot ids are equal, the save captures the pre-restore state.
REQ-023 Priority SHALL be flush > restore > push/pop; flush clears all entries, tos, count and all checkpoint valid bits at the next edge.

Reset
REQ-024 Asserting rst_i at any time SHALL immediately zero all entries, tos_q, count_q and checkpoints; outputs read data_o=0, empty_o=1, overflow_o=0 (overflow_o=0 whenever push_i=0).

Configuration
REQ-025 With RAS_RECURSION_CNT_EN defined, each entry SHALL carry a CNT_W-bit counter (saved and restored with the entry):
- push-only with count_q>0, data_i equal to top ra and counter not saturated: increment the counter only;
- pop-only with counter>0: decrement the counter only; tos unchanged.
Without the macro, no counters exist and every push allocates an entry.

Structure
REQ-026 Checkpoint-slot struct field widths and priority encodings SHALL live in shared package ras_pkg; ras_t remains a parameter.
REQ-027 The checkpoint array SHALL be a sub-module ras_ckpt_store (NUM_CKPT slots, one write port, one read port, per-slot valid).

Verification
REQ-028 Push A1..A8 with DEPTH=8, then push A9 -> overflow_o=1 in that cycle; 8 pops return A9..A2; the 9th pop gives empty_o=1, data_o.valid=0.
REQ-029 Push 0x100, save slot 1, pop, push 0x200, restore slot 1 -> data_o.ra=0x100, count=1.
REQ-030 Flush together with restore and push -> next cycle empty_o=1; a later restore of slot 1 is a no-op.
REQ-031 With the macro defined, push 0x40 three times then pop once -> data_o.ra=0x40, one entry, counter=1; without the macro -> two entries remain.
REQ-032 Push and pop on an empty stack with data 0x80 -> data_o={0x80,1}, count=1; rst_i mid-sequence -> empty_o=1 before the next edge.

Source files
------------

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - core configuration record consumed by the branch-prediction blocks
//
// cva6_cfg_t carries the core-wide widths; only VLEN is consumed by the RAS.
package config_pkg;

  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32};

endpackage

// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared RAS operation encoding and checkpoint field-width helpers
//
// ras_op_e     : the single operation the stack performs in a cycle
// ras_decode   : resolves flush > restore > push/pop priority into ras_op_e
// ras_count_w  : width of an occupancy counter able to hold 0..depth
package ras_pkg;

  typedef enum logic [2:0] {
    RAS_OP_IDLE,
    RAS_OP_FLUSH,
    RAS_OP_RESTORE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_PUSH_POP
  } ras_op_e;

  // restore_ok must already include the slot-valid qualifier, so a restore
  // from an empty slot falls through to push/pop handling.
  function automatic ras_op_e ras_decode(input logic flush, input logic restore_ok,
                                         input logic push, input logic pop);
    if (flush)               return RAS_OP_FLUSH;
    else if (restore_ok)     return RAS_OP_RESTORE;
    else if (push && pop)    return RAS_OP_PUSH_POP;
    else if (push)           return RAS_OP_PUSH;
    else if (pop)            return RAS_OP_POP;
    else                     return RAS_OP_IDLE;
  endfunction

  function automatic int unsigned ras_count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ras_ckpt_store.sv
// rtl/ras_ckpt_store.sv - checkpoint slot array for RAS misprediction recovery
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        invalidate every slot (flush); wins over a write
//   we_i, waddr_i  write wdata_i into slot waddr_i and mark it valid
//   raddr_i        combinational read of slot contents (rdata_o) and valid bit (rvalid_o)
module ras_ckpt_store #(
  parameter int unsigned NUM_CKPT = 4,
  parameter type         slot_t   = logic,
  localparam int unsigned ID_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            we_i,
  input  logic [ID_W-1:0] waddr_i,
  input  slot_t           wdata_i,
  input  logic [ID_W-1:0] raddr_i,
  output slot_t           rdata_o,
  output logic            rvalid_o
);

  slot_t               slot_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CKPT; i++) slot_q[i] <= '0;
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      slot_q[waddr_i]  <= wdata_i;
      valid_q[waddr_i] <= 1'b1;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle save to the same slot
  // does not disturb a restore.
  assign rdata_o  = slot_q[raddr_i];
  assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/ras_spec.sv
// rtl/ras_spec.sv - circular return address stack with checkpoint save/restore
//
// Optional feature macro: RAS_RECURSION_CNT_EN (per-entry recursion counter).
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   flush_bp_i                          clear stack and invalidate checkpoints
//   push_i, pop_i, data_i               call push / return pop, address to push
//   ckpt_save_i, ckpt_save_id_i         snapshot current top into a slot
//   ckpt_restore_i, ckpt_restore_id_i   recover stack state from a slot
//   data_o                              predicted return {ra, valid}
//   empty_o, overflow_o                 stack empty / oldest entry lost this cycle
module ras_spec
  import ras_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type         ras_t    = logic,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_CKPT = 4,
  parameter int unsigned CNT_W    = 2,
  localparam int unsigned ID_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_bp_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [CVA6Cfg.VLEN-1:0] data_i,
  input  logic                    ckpt_save_i,
  input  logic [ID_W-1:0]         ckpt_save_id_i,
  input  logic                    ckpt_restore_i,
  input  logic [ID_W-1:0]         ckpt_restore_id_i,
  output ras_t                    data_o,
  output logic                    empty_o,
  output logic                    overflow_o
);

  localparam int unsigned VLEN     = CVA6Cfg.VLEN;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = ras_count_w(DEPTH);
  localparam logic [CNT_BITS-1:0] COUNT_FULL = CNT_BITS'(DEPTH);

  typedef struct packed {
    logic [VLEN-1:0] ra;
    logic            valid;
  } entry_t;

`ifdef RAS_RECURSION_CNT_EN
  typedef struct packed {
    logic [PTR_W-1:0]    tos;
    logic [CNT_BITS-1:0] count;
    entry_t              entry;
    logic [CNT_W-1:0]    rcnt;
  } slot_t;
`else
  typedef struct packed {
    logic [PTR_W-1:0]    tos;
    logic [CNT_BITS-1:0] count;
    entry_t              entry;
  } slot_t;
`endif

  entry_t              stack_q [DEPTH];
  logic [PTR_W-1:0]    tos_q;
  logic [CNT_BITS-1:0] count_q;
`ifdef RAS_RECURSION_CNT_EN
  logic [CNT_W-1:0]    rcnt_q [DEPTH];
`endif

  slot_t      save_slot;
  slot_t      rest_slot;
  logic       rest_valid;
  ras_op_e    op;
  logic       merge_push;
  logic       merge_pop;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;
  entry_t     push_entry;
  entry_t     top_entry;

  assign tos_inc    = tos_q + 1'b1;
  assign tos_dec    = tos_q - 1'b1;
  assign push_entry = '{ra: data_i, valid: 1'b1};

  assign save_slot.tos   = tos_q;
  assign save_slot.count = count_q;
  assign save_slot.entry = stack_q[tos_q];
`ifdef RAS_RECURSION_CNT_EN
  assign save_slot.rcnt  = rcnt_q[tos_q];
`endif

  ras_ckpt_store #(
    .NUM_CKPT (NUM_CKPT),
    .slot_t   (slot_t)
  ) u_ckpt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (flush_bp_i),
    .we_i     (ckpt_save_i),
    .waddr_i  (ckpt_save_id_i),
    .wdata_i  (save_slot),
    .raddr_i  (ckpt_restore_id_i),
    .rdata_o  (rest_slot),
    .rvalid_o (rest_valid)
  );

  assign op = ras_decode(flush_bp_i, ckpt_restore_i && rest_valid, push_i, pop_i);

`ifdef RAS_RECURSION_CNT_EN
  // A repeated call to the same return address only bumps the counter of the
  // top entry; a return first drains that counter before moving tos.
  assign merge_push = (op == RAS_OP_PUSH) && (count_q != '0) &&
                      (stack_q[tos_q].ra == data_i) && (rcnt_q[tos_q] != '1);
  assign merge_pop  = (op == RAS_OP_POP) && (count_q != '0) && (rcnt_q[tos_q] != '0);
`else
  assign merge_push = 1'b0;
  assign merge_pop  = 1'b0;
`endif

  assign overflow_o = (op == RAS_OP_PUSH) && !merge_push && (count_q == COUNT_FULL);

  assign top_entry = (count_q != '0) ? stack_q[tos_q] : '0;
  assign data_o    = ras_t'(top_entry);
  assign empty_o   = (count_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tos_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
`ifdef RAS_RECURSION_CNT_EN
      for (int i = 0; i < DEPTH; i++) rcnt_q[i] <= '0;
`endif
    end else begin
      unique case (op)
        RAS_OP_FLUSH: begin
          tos_q   <= '0;
          count_q <= '0;
          for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
`ifdef RAS_RECURSION_CNT_EN
          for (int i = 0; i < DEPTH; i++) rcnt_q[i] <= '0;
`endif
        end
        RAS_OP_RESTORE: begin
          // Only the saved top is rewritten; deeper entries were never
          // destroyed by pops, so they are still valid for the saved tos.
          tos_q                  <= rest_slot.tos;
          count_q                <= rest_slot.count;
          stack_q[rest_slot.tos] <= rest_slot.entry;
`ifdef RAS_RECURSION_CNT_EN
          rcnt_q[rest_slot.tos]  <= rest_slot.rcnt;
`endif
        end
        RAS_OP_PUSH: begin
          if (merge_push) begin
`ifdef RAS_RECURSION_CNT_EN
            rcnt_q[tos_q] <= rcnt_q[tos_q] + 1'b1;
`endif
          end else begin
            tos_q            <= tos_inc;
            stack_q[tos_inc] <= push_entry;
`ifdef RAS_RECURSION_CNT_EN
            rcnt_q[tos_inc]  <= '0;
`endif
            if (count_q != COUNT_FULL) count_q <= count_q + 1'b1;
          end
        end
        RAS_OP_POP: begin
          if (merge_pop) begin
`ifdef RAS_RECURSION_CNT_EN
            rcnt_q[tos_q] <= rcnt_q[tos_q] - 1'b1;
`endif
          end else if (count_q != '0) begin
            tos_q   <= tos_dec;
            count_q <= count_q - 1'b1;
          end
        end
        RAS_OP_PUSH_POP: begin
          stack_q[tos_q] <= push_entry;
`ifdef RAS_RECURSION_CNT_EN
          rcnt_q[tos_q]  <= '0;
`endif
          if (count_q == '0) count_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ras_spec.sv
// tb/tb_ras_spec.sv - self-checking bench for ras_spec against a behavioural stack model
`timescale 1ns/1ps
module tb_ras_spec;

  localparam config_pkg::cva6_cfg_t CFG = '{VLEN: 32'd32};
  localparam int DEPTH = 8;
  localparam int NCK   = 4;
`ifdef RAS_RECURSION_CNT_EN
  localparam bit REC_EN = 1'b1;
`else
  localparam bit REC_EN = 1'b0;
`endif
  localparam int RC_MAX = 3;

  typedef struct packed {
    logic [31:0] ra;
    logic        valid;
  } ras_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, push = 1'b0, pop = 1'b0, save = 1'b0, restore = 1'b0;
  logic [31:0] data = '0;
  logic [1:0]  sid = '0, rid = '0;
  ras_t        data_o;
  logic        empty_o, overflow_o;

  always #5 clk = ~clk;

  ras_spec #(
    .CVA6Cfg (CFG),
    .ras_t   (ras_t),
    .DEPTH   (DEPTH),
    .NUM_CKPT(NCK),
    .CNT_W   (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_bp_i       (flush),
    .push_i           (push),
    .pop_i            (pop),
    .data_i           (data),
    .ckpt_save_i      (save),
    .ckpt_save_id_i   (sid),
    .ckpt_restore_i   (restore),
    .ckpt_restore_id_i(rid),
    .data_o           (data_o),
    .empty_o          (empty_o),
    .overflow_o       (overflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: array of return addresses addressed modulo DEPTH.
  logic [31:0] m_ra [DEPTH];
  bit          m_v  [DEPTH];
  int          m_rc [DEPTH];
  int          m_tos, m_count;
  bit          ck_ok [NCK];
  int          ck_tos [NCK], ck_count [NCK], ck_rc [NCK];
  logic [31:0] ck_ra [NCK];
  bit          ck_v  [NCK];
  bit          ovf_exp, ovf_seen;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin m_ra[i] = '0; m_v[i] = 0; m_rc[i] = 0; end
    for (int i = 0; i < NCK; i++) ck_ok[i] = 0;
    m_tos = 0; m_count = 0;
  endtask

  task automatic model_step(input bit pu, input bit po, input logic [31:0] d,
                            input bit sv, input int si, input bit rs, input int ri, input bit fl);
    bit r_ok; int r_tos, r_count, r_rc; logic [31:0] r_ra; bit r_v;
    ovf_exp = 0;
    r_ok = ck_ok[ri]; r_tos = ck_tos[ri]; r_count = ck_count[ri];
    r_ra = ck_ra[ri]; r_v = ck_v[ri]; r_rc = ck_rc[ri];
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) begin m_ra[i] = '0; m_v[i] = 0; m_rc[i] = 0; end
      for (int i = 0; i < NCK; i++) ck_ok[i] = 0;
      m_tos = 0; m_count = 0;
      return;
    end
    if (sv) begin
      ck_ok[si] = 1; ck_tos[si] = m_tos; ck_count[si] = m_count;
      ck_ra[si] = m_ra[m_tos]; ck_v[si] = m_v[m_tos]; ck_rc[si] = m_rc[m_tos];
    end
    if (rs && r_ok) begin
      m_tos = r_tos; m_count = r_count;
      m_ra[r_tos] = r_ra; m_v[r_tos] = r_v; m_rc[r_tos] = r_rc;
    end else if (pu && po) begin
      m_ra[m_tos] = d; m_v[m_tos] = 1; m_rc[m_tos] = 0;
      if (m_count == 0) m_count = 1;
    end else if (pu) begin
      if (REC_EN && m_count > 0 && m_ra[m_tos] == d && m_rc[m_tos] < RC_MAX) begin
        m_rc[m_tos]++;
      end else begin
        if (m_count == DEPTH) ovf_exp = 1;
        m_tos = (m_tos + 1) % DEPTH;
        m_ra[m_tos] = d; m_v[m_tos] = 1; m_rc[m_tos] = 0;
        if (m_count < DEPTH) m_count++;
      end
    end else if (po && m_count > 0) begin
      if (REC_EN && m_rc[m_tos] > 0) m_rc[m_tos]--;
      else begin m_tos = (m_tos + DEPTH - 1) % DEPTH; m_count--; end
    end
  endtask

  function automatic ras_t exp_top();
    ras_t t;
    t = '0;
    if (m_count > 0) begin t.ra = m_ra[m_tos]; t.valid = m_v[m_tos]; end
    return t;
  endfunction

  // Drives one clock of stimulus starting at posedge+1, captures overflow_o
  // mid-cycle, and returns at the following posedge+1 with inputs idle.
  task automatic cycle(input bit pu, input bit po, input logic [31:0] d,
                       input bit sv, input int si, input bit rs, input int ri, input bit fl);
    push = pu; pop = po; data = d; save = sv; sid = 2'(si);
    restore = rs; rid = 2'(ri); flush = fl;
    #1;
    ovf_seen = overflow_o;
    model_step(pu, po, d, sv, si, rs, ri, fl);
    @(posedge clk); #1;
    push = 0; pop = 0; save = 0; restore = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL reset_data: got %h expected 0", data_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow_o); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] a [1:9];
    for (int i = 1; i <= 9; i++) a[i] = 32'h1000 + 32'(i) * 4;
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) cycle(1, 0, a[i], 0, 0, 0, 0, 0);
    n_checks++; if (ovf_seen !== 1'b0) $display("FAIL ovf_push8: got %b expected 0", ovf_seen); else n_pass++;
    n_checks++; if (data_o.ra !== a[8]) $display("FAIL ovf_top8: got %h expected %h", data_o.ra, a[8]); else n_pass++;
    cycle(1, 0, a[9], 0, 0, 0, 0, 0);
    n_checks++; if (ovf_seen !== 1'b1) $display("FAIL ovf_push9: got %b expected 1", ovf_seen); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (data_o.ra !== a[9-k] || data_o.valid !== 1'b1)
        $display("FAIL ovf_pop%0d: got %h/%b expected %h/1", k, data_o.ra, data_o.valid, a[9-k]);
      else n_pass++;
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
    end
    n_checks++; if (empty_o !== 1'b1) $display("FAIL ovf_empty8: got %b expected 1", empty_o); else n_pass++;
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (empty_o !== 1'b1 || data_o.valid !== 1'b0)
      $display("FAIL ovf_pop9: got empty=%b valid=%b expected 1/0", empty_o, data_o.valid); else n_pass++;
  endtask

  task automatic test_checkpoint();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 32'h100, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'h200, 0, 0, 0, 0, 0);
    n_checks++; if (data_o.ra !== 32'h200) $display("FAIL ckpt_pre: got %h expected 200", data_o.ra); else n_pass++;
    cycle(1, 0, 32'h300, 0, 0, 1, 1, 0);
    n_checks++; if (data_o !== '{ra: 32'h100, valid: 1'b1})
      $display("FAIL ckpt_restore: got %h expected 100/1", data_o); else n_pass++;
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (empty_o !== 1'b1) $display("FAIL ckpt_count1: got %b expected 1", empty_o); else n_pass++;
  endtask

  task automatic test_flush();
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0, 0);
    cycle(1, 0, 32'h20, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'h30, 0, 0, 1, 1, 1);
    n_checks++; if (empty_o !== 1'b1 || data_o.valid !== 1'b0)
      $display("FAIL flush_empty: got empty=%b valid=%b expected 1/0", empty_o, data_o.valid); else n_pass++;
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    n_checks++; if (empty_o !== 1'b1) $display("FAIL flush_restore_noop: got %b expected 1", empty_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 32'h11, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 0, 0, 0);
    cycle(1, 0, 32'h22, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 1, 2, 0);
    n_checks++; if (data_o.ra !== 32'h11) $display("FAIL b2b_restore: got %h expected 11", data_o.ra); else n_pass++;
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 2, 0);
    n_checks++; if (data_o.ra !== 32'h22 || empty_o !== 1'b0)
      $display("FAIL b2b_presave: got %h/%b expected 22/0", data_o.ra, empty_o); else n_pass++;
  endtask

  task automatic test_recursion();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) cycle(1, 0, 32'h40, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (data_o !== '{ra: 32'h40, valid: 1'b1})
      $display("FAIL rec_top: got %h expected 40/1", data_o); else n_pass++;
    // Seven distinct pushes: with merging one 0x40 entry remains (fills to 8);
    // without it two remain and the seventh push overflows.
    for (int i = 1; i <= 7; i++) cycle(1, 0, 32'h400 + 32'(i), 0, 0, 0, 0, 0);
    n_checks++; if (ovf_seen !== (REC_EN ? 1'b0 : 1'b1))
      $display("FAIL rec_ovf: got %b expected %b", ovf_seen, !REC_EN); else n_pass++;
    n_checks++; if (data_o.ra !== 32'h407) $display("FAIL rec_top7: got %h expected 407", data_o.ra); else n_pass++;
  endtask

  task automatic test_push_pop_empty();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 32'h80, 0, 0, 0, 0, 0);
    n_checks++; if (data_o !== '{ra: 32'h80, valid: 1'b1})
      $display("FAIL pp_data: got %h expected 80/1", data_o); else n_pass++;
    cycle(1, 0, 32'h90, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (data_o.ra !== 32'h80) $display("FAIL pp_under: got %h expected 80", data_o.ra); else n_pass++;
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (empty_o !== 1'b1) $display("FAIL pp_count1: got %b expected 1", empty_o); else n_pass++;
    cycle(1, 0, 32'h55, 0, 0, 0, 0, 0);
    push = 1; data = 32'hA0;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (empty_o !== 1'b1) $display("FAIL midrst_empty: got %b expected 1", empty_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL midrst_data: got %h expected 0", data_o); else n_pass++;
    push = 0; data = '0;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      int r, si, ri;
      bit pu, po, sv, rs, fl;
      logic [31:0] d;
      r  = $urandom_range(0, 99);
      fl = (r < 2);
      pu = $urandom_range(0, 1);
      po = $urandom_range(0, 2) == 0;
      sv = $urandom_range(0, 6) == 0;
      rs = $urandom_range(0, 9) == 0;
      si = $urandom_range(0, NCK - 1);
      ri = $urandom_range(0, NCK - 1);
      d  = 32'($urandom_range(1, 4)) * 32'h10;
      cycle(pu, po, d, sv, si, rs, ri, fl);
      n_checks++; if (ovf_seen !== ovf_exp) $display("FAIL rnd_ovf[%0d]: got %b expected %b", n, ovf_seen, ovf_exp); else n_pass++;
      n_checks++; if (data_o !== exp_top()) $display("FAIL rnd_data[%0d]: got %h expected %h", n, data_o, exp_top()); else n_pass++;
      n_checks++; if (empty_o !== (m_count == 0)) $display("FAIL rnd_empty[%0d]: got %b expected %b", n, empty_o, m_count == 0); else n_pass++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_overflow();
    test_checkpoint();
    test_flush();
    test_back_to_back();
    test_recursion();
    test_push_pop_empty();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
